fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch control stage directly downstream of the program-counter register.
- Reads the current PC value and issues a word read to instruction memory over a req/ack handshake.
- Captures the returned word into an instruction register (IR) for decode.
- Drives the PC's increment and load controls, so the PC advances by 4 or is redirected by a branch/jump.

Parameters:
- ADDR_W, 32, width of PC, memory address and redirect target
- DATA_W, 32, instruction word width

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  reset, synchronous, active-low (0 at posedge resets the block)
- pc_val  input  ADDR_W  current PC register output
- pc_inc  output  1  PC increment-by-4 request, one cycle
- pc_ld  output  1  PC load request, one cycle
- pc_ld_val  output  ADDR_W  value for PC to load when pc_ld=1
- mem_req  output  1  instruction read request
- mem_addr  output  ADDR_W  read address; equals pc_val while mem_req=1, else 0
- mem_ack  input  1  read complete; mem_rdata valid this cycle
- mem_rdata  input  DATA_W  instruction word
- ir_valid  output  1  IR holds an instruction for decode
- ir_ready  input  1  decode accepts IR this cycle
- ir  output  DATA_W  instruction register
- ir_pc  output  ADDR_W  address the IR word was fetched from
- redirect_valid  input  1  branch/jump taken
- redirect_addr  input  ADDR_W  branch/jump target

Behaviour:
- Reset (rst=0 at posedge): state IDLE; ir, ir_pc, pc_ld_val = 0; ir_valid = 0. In IDLE, pc_inc, pc_ld and mem_req are all 0.
- FSM states: IDLE, REQ, ADV, WAIT, DRAIN, LOAD.
- pc_inc=1 only in ADV; pc_ld=1 only in LOAD; mem_req=1 only in REQ and DRAIN. pc_inc and pc_ld are never 1 together.
- IDLE: next state REQ unconditionally.
- REQ: mem_addr=pc_val; the PC is held stable, so the address is stable until ack.
  - On mem_ack: ir<=mem_rdata, ir_pc<=pc_val, ir_valid<=1, next state ADV.
  - With no ack: stay in REQ.
- ADV: pc_inc=1 for one cycle; the PC is pc_val+4 in the following cycle.
  - Next state REQ if ir_ready=1 this cycle (IR consumed), else WAIT.
- WAIT: hold. On ir_ready=1, next state REQ.
- IR handshake: ir_valid=1 and ir_ready=1 at posedge clears ir_valid. ir and ir_pc keep their last value.
- REQ is entered only with the IR empty or being emptied in that same edge, so a capture never overwrites a live IR.
- Redirect (redirect_valid=1), highest priority:
  - pc_ld_val<=redirect_addr and ir_valid<=0 (flush) in all states.
  - REQ without ack: the outstanding read must complete, so the next state is DRAIN. mem_req stays 1 with the same address.
  - REQ with simultaneous mem_ack: discard mem_rdata (IR not written, ir_valid=0), next state LOAD.
  - DRAIN: on mem_ack, discard data and go to LOAD. Further redirects while draining overwrite pc_ld_val; the latest target wins.
  - ADV: pc_inc still asserts this cycle (Moore output); the next state is LOAD, which overrides the increment.
  - IDLE, WAIT, LOAD: next state LOAD. A redirect in LOAD re-latches pc_ld_val and stays in LOAD one more cycle.
- LOAD: pc_ld=1 for one cycle; the PC holds pc_ld_val in the next cycle. Next state REQ.
- Minimum steady-state throughput: one instruction per 2 cycles (REQ with immediate ack, then ADV).
- No address arithmetic is done in the block; wrap-around of PC+4 belongs to the PC register.
- Reset asserted mid-operation (any state, including DRAIN) returns the block to IDLE at that edge.
  - The outstanding memory read is abandoned; memory must tolerate req dropping on reset.

Decomposition:
- Shared include file fetch_defs.vh holds the state encoding localparams: IDLE=3'd0, REQ=3'd1, ADV=3'd2, WAIT=3'd3, DRAIN=3'd4, LOAD=3'd5.
- The same file holds the instruction-word width constant shared with decode.
- No sub-module: FSM plus IR/ir_pc/pc_ld_val registers in one module.

Test Plan:
- Reset then sequential fetch: rst low 2 cycles then high. mem_ack=1 in every REQ cycle, ir_ready=1, PC model starting at 0.
  - mem_req=1 in cycle 1 with mem_addr=0.
  - ir_valid=1, ir_pc=0 and pc_inc=1 in cycle 2.
  - mem_addr=4 in cycle 3, then 8 in cycle 5.
- Memory latency: mem_ack delayed 3 cycles.
  - mem_req held with constant mem_addr=0x10 for 3 cycles; pc_inc stays 0 until the cycle after ack.
- Decode stall: ir_ready=0 for 4 cycles after capture of 0x20.
  - FSM sits in WAIT with ir held and no mem_req.
  - ir_ready=1 gives mem_req with addr 0x24 in the next cycle.
- Redirect with outstanding read: redirect_valid (addr 0x100) in REQ without ack; ack 2 cycles later.
  - mem_req held at the old address; data discarded, ir_valid=0.
  - pc_ld=1 with pc_ld_val=0x100, then mem_addr=0x100.
- Redirect during ADV, and redirect coincident with ack.
  - ADV case: pc_inc then pc_ld on consecutive cycles, never both.
  - Coincident case: IR not written, LOAD next cycle.
  - Back-to-back redirects 0x200 then 0x300 in DRAIN: pc_ld_val=0x300.
- Reset mid-DRAIN: rst=0 at the next edge gives IDLE, mem_req=0, ir_valid=0, pc_ld_val=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// fetch_sequencer_pkg : state type and helpers for the fetch sequencer
// Rev 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  `include "fetch_defs.vh"

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = IDLE,
    ST_REQ   = REQ,
    ST_ADV   = ADV,
    ST_WAIT  = WAIT,
    ST_DRAIN = DRAIN,
    ST_LOAD  = LOAD
  } state_e;

  // DRAIN keeps the read alive after a redirect, so it also requests.
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_REQ) || (s == ST_DRAIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_defs.vh
`default_nettype none
// ============================================================================
// fetch_defs.vh : fetch FSM state encoding and instruction-word width
// Rev 1.0 - initial release
// ============================================================================
`ifndef FETCH_DEFS_VH
`define FETCH_DEFS_VH

localparam int         STATE_W = 3;
localparam logic [2:0] IDLE    = 3'd0;
localparam logic [2:0] REQ     = 3'd1;
localparam logic [2:0] ADV     = 3'd2;
localparam logic [2:0] WAIT    = 3'd3;
localparam logic [2:0] DRAIN   = 3'd4;
localparam logic [2:0] LOAD    = 3'd5;

// Instruction word width, shared with the decode stage.
localparam int         INSTR_W = 32;

`endif
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : instruction fetch control between PC register and decode
// Rev 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_val,
  output logic              pc_inc,
  output logic              pc_ld,
  output logic [ADDR_W-1:0] pc_ld_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr
);

  state_e              state_q,     state_d;
  logic [DATA_W-1:0]   ir_q,        ir_d;
  logic [ADDR_W-1:0]   ir_pc_q,     ir_pc_d;
  logic                ir_valid_q,  ir_valid_d;
  logic [ADDR_W-1:0]   pc_ld_val_q, pc_ld_val_d;
  logic                mem_req_q,   mem_req_d;
  logic                pc_inc_q,    pc_inc_d;
  logic                pc_ld_q,     pc_ld_d;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    pc_ld_val_d = pc_ld_val_q;
    ir_valid_d  = ir_valid_q && !ir_ready;

    // A redirect always wins: latch the newest target and flush the IR.
    if (redirect_valid) begin
      pc_ld_val_d = redirect_addr;
      ir_valid_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = redirect_valid ? ST_LOAD : ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid) begin
          state_d = mem_ack ? ST_LOAD : ST_DRAIN;
        end else if (mem_ack) begin
          ir_d       = mem_rdata;
          ir_pc_d    = pc_val;
          ir_valid_d = 1'b1;
          state_d    = ST_ADV;
        end
      end
      ST_ADV: begin
        if (redirect_valid) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ir_ready ? ST_REQ : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_d = ST_LOAD;
        end else if (ir_ready) begin
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // Returning data belongs to the abandoned path and is dropped.
        if (mem_ack) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = redirect_valid ? ST_LOAD : ST_REQ;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_req_d = is_mem_state(state_d);
    pc_inc_d  = (state_d == ST_ADV);
    pc_ld_d   = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      pc_ld_val_q <= '0;
      mem_req_q   <= 1'b0;
      pc_inc_q    <= 1'b0;
      pc_ld_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      pc_ld_val_q <= pc_ld_val_d;
      mem_req_q   <= mem_req_d;
      pc_inc_q    <= pc_inc_d;
      pc_ld_q     <= pc_ld_d;
    end
  end

  assign pc_inc    = pc_inc_q;
  assign pc_ld     = pc_ld_q;
  assign pc_ld_val = pc_ld_val_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_req_q ? pc_val : '0;
  assign ir_valid  = ir_valid_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;

endmodule
`default_nettype wire
